// File: rtl/regfile_2r1w_if.sv
// Bus interface for the 2-read / 1-write register file.
// The master drives the write port and both read requests; the slave
// returns the two registered read results.
interface regfile_2r1w_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             rena;
  logic [AW-1:0]    addra;
  logic [WIDTH-1:0] douta;
  logic             renb;
  logic [AW-1:0]    addrb;
  logic [WIDTH-1:0] doutb;

  modport master (
    output wen, waddr, wdata, rena, addra, renb, addrb,
    input  douta, doutb
  );

  modport slave (
    input  wen, waddr, wdata, rena, addra, renb, addrb,
    output douta, doutb
  );
endinterface

// File: rtl/regfile_2r1w.sv
// CPU register file: 2**AW registers of WIDTH bits, one write port and two
// independent read ports with one cycle of latency. A write landing in the
// same cycle as a read of the same address is forwarded to that reader.
// With ZERO0=1, register 0 reads as zero and ignores writes.
// The interface instance must be built with the same WIDTH and AW.
module regfile_2r1w #(
  parameter int WIDTH = 32,
  parameter int AW    = 4,
  parameter bit ZERO0 = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  regfile_2r1w_if.slave bus
);

  localparam int NREG = 2 ** AW;

  logic [WIDTH-1:0] regs [NREG];
  logic             write_ok;
  logic [WIDTH-1:0] value_a;
  logic [WIDTH-1:0] value_b;

  // A write to register 0 is dropped when it is hardwired to zero.
  assign write_ok = bus.wen && !(ZERO0 && (bus.waddr == '0));

  // Resolve the value each read port will capture: zero register first,
  // then the same-cycle write (bypass), otherwise the stored content.
  always_comb begin
    // NOTE: every variable gets a default at the top of the block so no
    // path leaves it unassigned, which would otherwise infer a latch.
    value_a = regs[bus.addra];
    value_b = regs[bus.addrb];
    if (bus.wen && (bus.waddr == bus.addra)) value_a = bus.wdata;
    if (bus.wen && (bus.waddr == bus.addrb)) value_b = bus.wdata;
    if (ZERO0 && (bus.addra == '0)) value_a = '0;
    if (ZERO0 && (bus.addrb == '0)) value_b = '0;
  end

  // Register array: cleared by reset, updated by the single write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage array is reset as well so no register can ever
      // return X; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (write_ok) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Read port A output register; holds its value while rena is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         bus.douta <= '0;
    else if (bus.rena) bus.douta <= value_a;
  end

  // Read port B output register; holds its value while renb is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         bus.doutb <= '0;
    else if (bus.renb) bus.doutb <= value_b;
  end

endmodule
